// File: rtl/pipe_dmem_arbiter.sv
// pipe_dmem_arbiter: shares the data-memory port between the CPU MEM stage and a DMA master.
// The CPU has priority; a run counter bounds how long a pending DMA can be starved.
module pipe_dmem_arbiter #(
  parameter int MAX_CPU_RUN = 4
) (
  input  logic        i_clock,
  input  logic        i_resetn,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic [31:0] o_dma_rdata,
  output logic        o_dma_ack,
  output logic        o_dma_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_datain,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_dataout
);
  typedef enum logic {S_CPU, S_DMA} state_t;
  localparam logic [3:0] MAX_RUN = 4'(MAX_CPU_RUN);
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_run_cnt, w_run_cnt_nxt;
  logic [31:0] r_dma_rdata;
  logic        r_dma_err;
  logic        w_dma_go;
  logic        w_io;
  assign o_dma_ack   = (r_state == S_DMA);
  assign o_dma_err   = r_dma_err;
  assign o_dma_rdata = r_dma_rdata;
  assign o_cpu_rdata = i_mem_dataout;
  assign w_io        = (i_dma_addr[31:8] == 24'hffffff);
  assign w_dma_go    = i_dma_req & ~o_dma_ack & (~i_cpu_req | (r_run_cnt == MAX_RUN));
  always_comb begin
    w_state_nxt   = S_CPU;
    w_run_cnt_nxt = r_run_cnt;
    o_mem_addr    = i_cpu_addr;
    o_mem_datain  = i_cpu_wdata;
    o_mem_we      = i_cpu_we & i_cpu_req;
    o_cpu_stall   = 1'b0;
    w_state_nxt   = (r_state == S_CPU && w_dma_go) ? S_DMA : S_CPU;
    // Counter only advances while a DMA is waiting and the CPU keeps taking the port
    w_run_cnt_nxt = (w_dma_go | ~i_dma_req) ? 4'd0 :
                    (i_cpu_req & ~o_dma_ack & (r_run_cnt != MAX_RUN)) ? r_run_cnt + 4'd1 :
                    r_run_cnt;
    if (w_dma_go) begin
      o_mem_addr   = i_dma_addr;
      o_mem_datain = i_dma_wdata;
      o_mem_we     = i_dma_we & ~w_io;
      o_cpu_stall  = i_cpu_req;
    end
  end
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state     <= S_CPU;
      r_run_cnt   <= 4'd0;
      r_dma_err   <= 1'b0;
      r_dma_rdata <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_cnt <= w_run_cnt_nxt;
      r_dma_err <= w_dma_go & w_io;
      if (w_dma_go & ~w_io & ~i_dma_we) r_dma_rdata <= i_mem_dataout;
    end
  end
endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// tb_pipe_dmem_arbiter: table-driven cycle vectors plus reset sequences for pipe_dmem_arbiter.
module tb_pipe_dmem_arbiter;
  logic        clk = 1'b0;
  logic        resetn, cpu_req, cpu_we, cpu_stall, dma_req, dma_we, dma_ack, dma_err, mem_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic [31:0] mem [0:63] = '{default: 32'd0};
  int          n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  pipe_dmem_arbiter #(.MAX_CPU_RUN(4)) dut (
    .i_clock(clk), .i_resetn(resetn),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata), .o_dma_ack(dma_ack), .o_dma_err(dma_err),
    .o_mem_addr(mem_addr), .o_mem_datain(mem_datain), .o_mem_we(mem_we),
    .i_mem_dataout(mem_dataout)
  );

  assign mem_dataout = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_datain;

  typedef struct {
    logic        c, cwe;
    logic [31:0] caddr;
    logic        d, dwe;
    logic [31:0] daddr, dwd;
    logic        stall, mwe;
    logic [31:0] maddr;
    logic        ack, err;
    logic [31:0] rdata;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic c, cwe, input logic [31:0] caddr, input logic d, dwe,
                     input logic [31:0] daddr, dwd, input logic stall, mwe,
                     input logic [31:0] maddr, input logic ack, err, input logic [31:0] rdata);
    vec_t v;
    v = '{c, cwe, caddr, d, dwe, daddr, dwd, stall, mwe, maddr, ack, err, rdata};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic c, cwe, input logic [31:0] caddr, input logic d, dwe,
                       input logic [31:0] daddr, dwd);
    cpu_req = c; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = 32'hC0DE;
    dma_req = d; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 32'h40, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_ack", -1, 32'(dma_ack), 0);
    check("rst_err", -1, 32'(dma_err), 0);
    check("rst_stall", -1, 32'(cpu_stall), 0);
    check("rst_rdata", -1, dma_rdata, 0);
    // DMA-only write then read back
    add(0,0,32'h40, 1,1,32'h10,32'hA5A5, 0,1,32'h10, 0,0,32'h0);
    add(0,0,32'h40, 1,1,32'h10,32'hA5A5, 0,0,32'h40, 1,0,32'h0);
    add(0,0,32'h40, 1,0,32'h10,32'h0,    0,0,32'h10, 0,0,32'h0);
    add(0,0,32'h40, 0,0,32'h0, 32'h0,    0,0,32'h40, 1,0,32'hA5A5);
    // contention: CPU wins four times, then DMA forced in
    for (int i = 0; i < 4; i++) add(1,0,32'h40, 1,1,32'h20,32'h1234, 0,0,32'h40, 0,0,32'hA5A5);
    add(1,0,32'h40, 1,1,32'h20,32'h1234, 1,1,32'h20, 0,0,32'hA5A5);
    add(1,0,32'h40, 1,1,32'h20,32'h1234, 0,0,32'h40, 1,0,32'hA5A5);
    add(1,1,32'h44, 0,0,32'h0, 32'h0,    0,1,32'h44, 0,0,32'hA5A5);
    // IO-window reject
    add(0,0,32'h40, 1,1,32'hffffff20,32'hDEAD, 0,0,32'hffffff20, 0,0,32'hA5A5);
    add(0,0,32'h40, 1,1,32'hffffff20,32'hDEAD, 0,0,32'h40, 1,1,32'hA5A5);
    add(0,0,32'h40, 0,0,32'h0, 32'h0,    0,0,32'h40, 0,0,32'hA5A5);
    add(0,0,32'h40, 1,0,32'h20,32'h0,    0,0,32'h20, 0,0,32'hA5A5);
    add(0,0,32'h40, 0,0,32'h0, 32'h0,    0,0,32'h40, 1,0,32'h1234);
    // run counter clears when DMA request drops
    for (int i = 0; i < 2; i++) add(1,0,32'h40, 1,0,32'h44,32'h0, 0,0,32'h40, 0,0,32'h1234);
    add(1,0,32'h40, 0,0,32'h0, 32'h0,    0,0,32'h40, 0,0,32'h1234);
    for (int i = 0; i < 4; i++) add(1,0,32'h40, 1,0,32'h44,32'h0, 0,0,32'h40, 0,0,32'h1234);
    add(1,0,32'h40, 1,0,32'h44,32'h0,    1,0,32'h44, 0,0,32'h1234);
    add(0,0,32'h40, 0,0,32'h0, 32'h0,    0,0,32'h40, 1,0,32'hC0DE);
    foreach (vq[i]) begin
      @(posedge clk);
      #1 drive(vq[i].c, vq[i].cwe, vq[i].caddr, vq[i].d, vq[i].dwe, vq[i].daddr, vq[i].dwd);
      @(negedge clk);
      check("cpu_stall", i, 32'(cpu_stall), 32'(vq[i].stall));
      check("mem_we", i, 32'(mem_we), 32'(vq[i].mwe));
      check("mem_addr", i, mem_addr, vq[i].maddr);
      check("dma_ack", i, 32'(dma_ack), 32'(vq[i].ack));
      check("dma_err", i, 32'(dma_err), 32'(vq[i].err));
      check("dma_rdata", i, dma_rdata, vq[i].rdata);
      check("cpu_rdata", i, cpu_rdata, mem[vq[i].maddr[7:2]]);
    end
    // reset asserted during a DMA write grant: write lands, ack suppressed
    @(posedge clk);
    #1 resetn = 1'b0;
    drive(0, 0, 32'h40, 1, 1, 32'h50, 32'h77);
    @(negedge clk);
    check("midrst_mem_we", 100, 32'(mem_we), 1);
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(0, 0, 32'h40, 0, 0, 0, 0);
    @(negedge clk);
    check("midrst_ack", 101, 32'(dma_ack), 0);
    check("midrst_rdata", 101, dma_rdata, 0);
    check("midrst_write", 101, mem[20], 32'h77);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 drive(1, 0, 32'h40, 1, 0, 32'h50, 0);
      @(negedge clk);
      check("midrst_run", 102 + i, 32'(cpu_stall), (i == 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1 drive(0, 0, 32'h40, 0, 0, 0, 0);
    @(negedge clk);
    check("midrst_ack2", 107, 32'(dma_ack), 1);
    check("midrst_rdata2", 107, dma_rdata, 32'h77);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
